// File: rtl/seq_divider_pkg.sv
// Shared FSM state encodings and debug-state width for seq_divider.
// Pure declarations; no logic, no latency, no backpressure.
package seq_divider_pkg;

   localparam int CS_W = 3;

   typedef enum logic [CS_W-1:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/seq_divider_dp.sv
// Restoring-divider datapath: operand capture, one quotient bit per ITER cycle, sign fix-up, result hold.
// Sign logic exists only with SEQ_DIVIDER_SIGNED_EN; strobes come from the FSM, so there is no backpressure.
module seq_divider_dp #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap,
   input  logic             load,
   input  logic             iter,
   input  logic             fix,
   input  logic             fin,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             div_zero,
   output logic             cnt_last,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             error,
   output logic             done
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   diff;

   // Trial subtraction of the divisor from the left-shifted partial remainder.
   assign diff     = {r_q, x_q[WIDTH-1]} - {1'b0, y_q};
   assign div_zero = (b_q == '0);
   assign cnt_last = (cnt_q == CNT_W'(1));

`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             smode_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic             ovf_q;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign a_mag = (smode_q && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag = (smode_q && b_q[WIDTH-1]) ? -b_q : b_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         smode_q <= 1'b0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (cap) begin
         smode_q <= signed_mode;
      end else if (load) begin
         neg_q_q <= smode_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
         neg_r_q <= smode_q && a_q[WIDTH-1];
         ovf_q   <= smode_q && (a_q == MIN_NEG) && (b_q == '1);
      end
   end
`else
   logic unused_mode;
   assign unused_mode = signed_mode ^ fix;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         r_q   <= '0;
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= '0;
      end else if (cap) begin
         a_q <= dividend;
         b_q <= divisor;
      end else if (load) begin
         r_q   <= '0;
         cnt_q <= CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
         x_q   <= a_mag;
         y_q   <= b_mag;
`else
         x_q   <= a_q;
         y_q   <= b_q;
`endif
      end else if (iter) begin
         cnt_q <= cnt_q - CNT_W'(1);
         if (!diff[WIDTH]) begin
            r_q <= diff[WIDTH-1:0];
            x_q <= {x_q[WIDTH-2:0], 1'b1};
         end else begin
            r_q <= {r_q[WIDTH-2:0], x_q[WIDTH-1]};
            x_q <= {x_q[WIDTH-2:0], 1'b0};
         end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      else if (fix) begin
         if (neg_q_q) x_q <= -x_q;
         if (neg_r_q) r_q <= -r_q;
      end
`endif
   end

   // Results are published one edge after DONE and then held until the next run finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         error     <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= fin;
         if (cap) begin
            error <= 1'b0;
         end else if (fin) begin
            if (div_zero) begin
               quotient  <= '1;
               remainder <= a_q;
               error     <= 1'b1;
            end else begin
               quotient  <= x_q;
               remainder <= r_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
               error     <= ovf_q;
`else
               error     <= 1'b0;
`endif
            end
         end
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider; done rises WIDTH+3 edges after go (2 on divide-by-zero); go ignored while busy.
// Signed operation and overflow detection are built in only with SEQ_DIVIDER_SIGNED_EN defined.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             error,
   output logic [CS_W-1:0]  cs
);

   state_t state;
   state_t nxt;
   logic   cap;
   logic   load;
   logic   iter;
   logic   fix;
   logic   fin;
   logic   div_zero;
   logic   cnt_last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt  = state;
      cap  = 1'b0;
      load = 1'b0;
      iter = 1'b0;
      fix  = 1'b0;
      fin  = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               cap = 1'b1;
               nxt = LOAD;
            end
         end
         LOAD: begin
            load = 1'b1;
            nxt  = div_zero ? DONE : ITER;
         end
         ITER: begin
            iter = 1'b1;
            if (cnt_last) nxt = FIX;
         end
         FIX: begin
            fix = 1'b1;
            nxt = DONE;
         end
         DONE: begin
            fin = 1'b1;
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign cs   = state;

   seq_divider_dp #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk         (clk),
      .rst         (rst),
      .cap         (cap),
      .load        (load),
      .iter        (iter),
      .fix         (fix),
      .fin         (fin),
      .signed_mode (signed_mode),
      .dividend    (dividend),
      .divisor     (divisor),
      .div_zero    (div_zero),
      .cnt_last    (cnt_last),
      .quotient    (quotient),
      .remainder   (remainder),
      .error       (error),
      .done        (done)
   );

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=8; expectations follow SEQ_DIVIDER_SIGNED_EN when defined.
module tb_seq_divider;

   logic       clk;
   logic       rst;
   logic       go;
   logic       signed_mode;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       done;
   logic       busy;
   logic       error;
   logic [2:0] cs;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int k      = 0;
   int lat    = 0;
   int seen   = 0;

`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [7:0] Q_M7_2   = 8'hFD;
   localparam logic [7:0] R_M7_2   = 8'hFF;
   localparam logic [7:0] Q_M128   = 8'h80;
   localparam logic [7:0] R_M128   = 8'h00;
   localparam logic       E_M128   = 1'b1;
`else
   localparam logic [7:0] Q_M7_2   = 8'd124;
   localparam logic [7:0] R_M7_2   = 8'd1;
   localparam logic [7:0] Q_M128   = 8'd0;
   localparam logic [7:0] R_M128   = 8'h80;
   localparam logic       E_M128   = 1'b0;
`endif

   seq_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .signed_mode (signed_mode),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .done        (done),
      .busy        (busy),
      .error       (error),
      .cs          (cs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
      go          = 1'b1;
      dividend    = a;
      divisor     = b;
      signed_mode = s;
      @(posedge clk);
      #1;
      k  = cyc;
      go = 1'b0;
   endtask

   task automatic wait_done();
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = cyc - k;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] eq, input logic [7:0] er, input logic ee, input int elat);
      launch(a, b, s);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_cs_load"}, 32'(cs), 32'd1);
      chk({tag, "_err_clr"}, 32'(error), 32'd0);
      wait_done();
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_q"}, 32'(quotient), 32'(eq));
      chk({tag, "_r"}, 32'(remainder), 32'(er));
      chk({tag, "_err"}, 32'(error), 32'(ee));
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      chk("rst_cs", 32'(cs), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 200/7 = 28 r 4, done at k+11; done lasts one cycle
      run("u200_7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 11);
      @(posedge clk); #1;
      chk("u200_7_done_pulse", 32'(done), 32'd0);
      chk("u200_7_hold_q", 32'(quotient), 32'd28);

      run("div0", 8'd55, 8'd0, 1'b0, 8'hFF, 8'd55, 1'b1, 2);
      @(posedge clk); #1;
      chk("div0_hold_err", 32'(error), 32'd1);

      run("s_m7_2", 8'hF9, 8'h02, 1'b1, Q_M7_2, R_M7_2, 1'b0, 11);
      @(posedge clk); #1;
      run("u_m7_2", 8'hF9, 8'h02, 1'b0, 8'd124, 8'd1, 1'b0, 11);
      @(posedge clk); #1;
      run("s_m128", 8'h80, 8'hFF, 1'b1, Q_M128, R_M128, E_M128, 11);
      @(posedge clk); #1;

      // reset in the 4th ITER cycle, with go raised alongside to test priority
      launch(8'd100, 8'd3, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("mid_cs_iter", 32'(cs), 32'd2);
      rst = 1'b1; go = 1'b1; dividend = 8'd9; divisor = 8'd3;
      @(posedge clk); #1;
      rst = 1'b0; go = 1'b0;
      chk("mid_rst_cs", 32'(cs), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_q", 32'(quotient), 32'd0);
      chk("mid_rst_r", 32'(remainder), 32'd0);
      chk("mid_rst_err", 32'(error), 32'd0);
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         if (done) seen++;
         @(posedge clk); #1;
      end
      chk("mid_no_done", 32'(seen), 32'd0);
      chk("mid_still_idle", 32'(cs), 32'd0);
      run("after_rst_9_3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 11);
      @(posedge clk); #1;

      // go during busy is ignored: latency still counts from the first go
      launch(8'd100, 8'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      go = 1'b1; dividend = 8'd50; divisor = 8'd5;
      @(posedge clk); #1;
      go = 1'b0; dividend = 8'd0; divisor = 8'd0;
      wait_done();
      chk("busy_go_lat", 32'(lat), 32'd11);
      chk("busy_go_q", 32'(quotient), 32'd14);
      chk("busy_go_r", 32'(remainder), 32'd2);

      // back-to-back: go raised in the done/IDLE cycle
      run("b2b_77_8", 8'd77, 8'd8, 1'b0, 8'd9, 8'd5, 1'b0, 11);
      run("b2b_255_16", 8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 1'b0, 11);
      @(posedge clk); #1;
      chk("final_done_low", 32'(done), 32'd0);
      chk("final_cs_idle", 32'(cs), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), iteration counter width.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port go, input, 1, start request, sampled only in IDLE.
REQ-006 SHALL have port signed_mode, input, 1, treat operands as two's complement; sampled with go.
REQ-007 SHALL have port dividend, input, WIDTH, numerator, captured on accepted go.
REQ-008 SHALL have port divisor, input, WIDTH, denominator, captured on accepted go.
REQ-009 SHALL have port quotient, output, WIDTH, registered result.
REQ-010 SHALL have port remainder, output, WIDTH, registered result.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when results are valid.
REQ-012 SHALL have port busy, output, 1, high from the cycle after an accepted go until done.
REQ-013 SHALL have port error, output, 1, divide-by-zero or signed overflow, valid with done.
REQ-014 SHALL have port cs, output, 3, current FSM state encoding (debug).

Function
REQ-015 SHALL implement an FSM with states IDLE=0, LOAD=1, ITER=2, FIX=3, DONE=4.
REQ-016 SHALL transition IDLE->LOAD on go=1; go while not IDLE SHALL be ignored.
REQ-017 SHALL, in LOAD, capture operand magnitudes, clear the partial remainder, and set the counter to WIDTH; divisor==0 SHALL branch LOAD->DONE with error=1.
REQ-018 SHALL, in ITER, perform one restoring step per cycle (shift {R,X} left, trial-subtract Y, set quotient bit on non-negative result) and decrement the counter; counter==1 SHALL advance ITER->FIX.
REQ-019 SHALL, in FIX, apply signs: quotient negated when operand signs differ, remainder takes the dividend's sign (truncating division); unsigned mode SHALL pass results unchanged.
REQ-020 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL give a fixed latency: go accepted at edge k -> done high after edge k+WIDTH+3; divide-by-zero -> done after edge k+2.
REQ-022 SHALL, on divide-by-zero, output quotient = all ones, remainder = dividend, error=1.
REQ-023 SHALL, on signed overflow (dividend = -2^(WIDTH-1), divisor = -1), output quotient = dividend, remainder = 0, error=1.
REQ-024 SHALL hold quotient, remainder, and error stable from done until the next accepted go; error SHALL clear on the next accepted go.
REQ-025 SHALL accept go=1 in the same cycle the FSM returns to IDLE (back-to-back operations with a one-cycle IDLE gap).

Reset
REQ-026 SHALL, with rst=1 at a clock edge, force state IDLE, quotient=0, remainder=0, done=0, busy=0, error=0, counter=0, cs=0.
REQ-027 SHALL abort any operation in progress when rst is asserted mid-operation, with no done pulse.
REQ-028 SHALL give rst priority over go in the same cycle.

Configuration
REQ-029 SHALL, with macro SEQ_DIVIDER_SIGNED_EN defined, honour signed_mode and include the FIX sign logic and overflow detection.
REQ-030 SHALL, without SEQ_DIVIDER_SIGNED_EN, ignore signed_mode, perform unsigned division only, and pass through FIX in one cycle unchanged (latency unchanged).

Structure
REQ-031 SHALL place the state enum/encodings (IDLE..DONE) and the cs width constant in shared package seq_divider_pkg.
REQ-032 SHALL split into the FSM in seq_divider and one datapath sub-module seq_divider_dp (R/X/Y registers, subtractor, counter, sign fix-up).

Verification (WIDTH=8)
REQ-033 SHALL check unsigned 200/7 -> quotient 28, remainder 4, error 0, done at edge k+11.
REQ-034 SHALL check divisor 0 with dividend 55 -> quotient 255, remainder 55, error 1, done at edge k+2.
REQ-035 SHALL check signed -7/2 (0xF9/0x02) -> quotient 0xFD (-3), remainder 0xFF (-1); without the macro -> 124, 1.
REQ-036 SHALL check signed -128/-1 -> quotient 0x80, remainder 0, error 1.
REQ-037 SHALL check rst asserted at ITER cycle 4 -> all outputs 0, state IDLE, no done; a following go of 9/3 -> 3, 0.
REQ-038 SHALL check go pulsed during busy -> ignored, result of the first operation unchanged; back-to-back go in IDLE gap -> second result correct.
